sine_rom_arbiter: RTL

- Shares one synchronous single-port sine ROM (1-cycle read latency) between NREQ sample requesters, e.g. two phase-offset sine channels.
- Arbitrates with round-robin priority and drives the ROM address.
- Captures each returned ROM word into a per-requester output register, marked by a one-cycle valid pulse.
- Sits between the channel address counters and the shared ROM instance.

---
 rtl/sinegen_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/sine_rom_arbiter.sv | 69 ++++++
 3 files changed

// File: rtl/sinegen_pkg.sv
// Shared constants and types for the sine generator slice (counters, ROM, ROM arbiter).
// Pure declarations; no logic.
package sinegen_pkg;

    localparam int SINE_ADDR_WIDTH = 8;
    localparam int SINE_DATA_WIDTH = 8;
    localparam int DEFAULT_NREQ    = 2;
    localparam int MAX_NREQ        = 8;

    // Sized for the largest legal requester count so every instance shares one index type.
    typedef logic [$clog2(MAX_NREQ)-1:0] req_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; the last winner has the lowest priority next cycle.
// Latency: combinational grant. Backpressure: a request stays pending until granted.
// The pointer advances only on cycles that produce a grant.
module rr_arbiter
    import sinegen_pkg::*;
#(
    parameter int N = DEFAULT_NREQ
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    req_idx_t ptr;
    req_idx_t win_idx;
    logic     win_any;
    int       k;

    always_comb begin
        gnt     = '0;
        win_idx = ptr;
        win_any = 1'b0;
        k       = 0;
        // Walk ptr+1 .. ptr+N with wraparound; the first set request wins.
        for (int s = 1; s <= N; s++) begin
            k = int'(ptr) + s;
            if (k >= N) k = k - N;
            if (!win_any && req[k]) begin
                gnt[k]  = 1'b1;
                win_idx = req_idx_t'(k);
                win_any = 1'b1;
            end
        end
        if (rst) begin
            gnt     = '0;
            win_any = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= req_idx_t'(N - 1);
        end else if (win_any) begin
            ptr <= win_idx;
        end
    end

endmodule

// File: rtl/sine_rom_arbiter.sv
// Shares one single-port sine ROM between NREQ requesters, returning data into per-requester registers.
// Latency: grant to rvalid is 2 cycles. Backpressure: requesters hold req until gnt; one grant per cycle.
// Words in flight when rst is asserted are discarded.
module sine_rom_arbiter
    import sinegen_pkg::*;
#(
    parameter int ADDR_WIDTH = SINE_ADDR_WIDTH,
    parameter int DATA_WIDTH = SINE_DATA_WIDTH,
    parameter int NREQ       = DEFAULT_NREQ
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*ADDR_WIDTH-1:0] addr,
    output logic [NREQ-1:0]            gnt,
    output logic [ADDR_WIDTH-1:0]      rom_addr,
    input  logic [DATA_WIDTH-1:0]      rom_dout,
    output logic [NREQ*DATA_WIDTH-1:0] rdata,
    output logic [NREQ-1:0]            rvalid
);

    req_idx_t gnt_idx;
    logic     gnt_any;
    logic     stg_vld;
    req_idx_t stg_idx;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    always_comb begin
        rom_addr = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                rom_addr = addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                gnt_idx  = req_idx_t'(k);
                gnt_any  = 1'b1;
            end
        end
    end

    // Stage remembers who owns the ROM word arriving next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld <= 1'b0;
            stg_idx <= '0;
            rdata   <= '0;
            rvalid  <= '0;
        end else begin
            stg_vld <= gnt_any;
            stg_idx <= gnt_idx;
            rvalid  <= '0;
            if (stg_vld) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (stg_idx == req_idx_t'(k)) begin
                        rdata[k*DATA_WIDTH +: DATA_WIDTH] <= rom_dout;
                        rvalid[k]                         <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
